// File: rtl/down_counter.sv
// Programmable WIDTH-bit down counter/timer with a one-cycle underflow pulse.
// Define DOWN_COUNTER_AUTO_RELOAD_EN to reload on terminal count instead of expiring.
module down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             busy,
   output logic             underflow
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_EXPIRED
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_reload;
   logic             r_underflow;
   logic             r_busy;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_count_nxt;
   logic [WIDTH-1:0] w_reload_nxt;
   logic             w_underflow_nxt;

   // State, count and flag registers; reset has top priority
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_reload    <= '0;
         r_underflow <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_count     <= w_count_nxt;
         r_reload    <= w_reload_nxt;
         r_underflow <= w_underflow_nxt;
         r_busy      <= (w_state_nxt == S_RUN);
      end
   end

   // Next-state: load beats enable; terminal step never wraps to all-ones
   always_comb begin
      w_state_nxt     = r_state;
      w_count_nxt     = r_count;
      w_reload_nxt    = r_reload;
      w_underflow_nxt = 1'b0;
      if (load) begin
         w_state_nxt  = S_RUN;
         w_count_nxt  = load_value;
         w_reload_nxt = load_value;
      end else if (r_state == S_RUN && enable) begin
         if (r_count != '0) begin
            w_count_nxt = r_count - WIDTH'(1);
         end else begin
            w_underflow_nxt = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            w_count_nxt = r_reload;
`else
            w_state_nxt = S_EXPIRED;
`endif
         end
      end
   end

   // Outputs: all registered except zero, decoded from the count register
   always_comb begin
      count     = r_count;
      zero      = (r_count == '0);
      busy      = r_busy;
      underflow = r_underflow;
   end

endmodule

// File: doc/down_counter.md
# down_counter

Programmable WIDTH-bit down counter/timer: the counting-down counterpart to the team's 4-bit up counter. It shares that counter's clk/enable handshake and self-checking bench style. Software or a controlling FSM loads a start value, and the block decrements once per enabled clock. It signals terminal count with a one-cycle underflow pulse, then either stops or reloads. Intended as the timeout/interval source beside the up counter in the same clock domain.

## Interface
- WIDTH, 4, counter width in bits (legal 2..16)
- clk  input  1  rising-edge clock, single domain
- reset  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- enable  input  1  count-down qualifier, sampled on rising clk
- load  input  1  load strobe; priority over enable
- load_value  input  WIDTH  start/reload value, captured when load=1
- count  output  WIDTH  current counter value (registered)
- zero  output  1  count == 0 (decoded from count register)
- busy  output  1  1 while in RUN state (registered)
- underflow  output  1  one-cycle pulse, registered, on terminal-count step

## Operation
- States: IDLE, RUN, EXPIRED. Priority per clock: reset > load > enable.
- Reset (reset==0 at posedge): state IDLE, count=0, reload register=0, underflow=0, busy=0, so zero=1.
- load=1 in any state: count<=load_value, reload register<=load_value, state<=RUN, underflow<=0.
- RUN, enable=1, count!=0: count<=count-1.
- RUN, enable=1, count==0 (terminal step):
  - underflow<=1 for exactly one cycle.
  - Next state and count depend on the configuration below.
- RUN, enable=0: count, state held; underflow<=0.
- IDLE and EXPIRED: enable ignored, count held, underflow=0.
- Only load or reset exits IDLE or EXPIRED.
- Arithmetic: modulo 2^WIDTH, but count never wraps to all-ones. The terminal step is handled explicitly.
- Period: a load of N gives N+1 enabled cycles from load to underflow, inclusive of the terminal step. load_value=0 underflows on the first enabled cycle.
- load coincident with the terminal step: load wins; no underflow pulse; count<=load_value.
- reset coincident with load or enable: reset wins.
- reset mid-RUN: returns to IDLE next edge; any pending underflow is cleared.

## Timing
- All outputs are registered except zero, which is combinational from count with no input-to-output path.
- load to count visible: 1 cycle (count valid after the load edge).
- Decrement latency: 1 cycle per enabled edge.
- underflow asserts in the cycle after the terminal edge and is high for 1 clk only.
- busy follows state with 1-cycle latency.
  - It rises the cycle after load.
  - It falls the cycle after the terminal step when auto-reload is off.
- No combinational loops. One always block for state/count; flags derived in the same clock.

## Configuration
- DOWN_COUNTER_AUTO_RELOAD_EN defined:
  - Terminal step loads count<=reload register and stays in RUN, so busy stays 1.
  - underflow pulses every N+1 enabled cycles: a periodic tick.
- Not defined:
  - Terminal step moves to EXPIRED with count held at 0 and busy<=0.
  - Further enable has no effect until load.

## Test plan
- Reset: drive reset=0 for 2 edges with load=1, enable=1 → count=0, zero=1, busy=0, underflow=0. Load is ignored.
- One-shot (macro off): load 5, enable=1 continuously.
  - Required: count 5,4,3,2,1,0, then underflow high for 1 cycle after the 6th enabled edge.
  - Then count=0, busy=0, and it stays so for 10 more enabled cycles.
- Auto-reload (macro on): load 3, enable=1 for 16 cycles → underflow pulses every 4 cycles (4 pulses), count sequence 3,2,1,0,3,2,….
- Enable gating: load 4, then alternate enable 1/0 → count decrements only on enable=1 edges. Underflow arrives after exactly 5 enabled edges.
- Collisions:
  - load 7 on the same edge as the terminal step → no underflow, count=7, busy=1.
  - load_value=0 then enable → underflow on the first enabled edge.
- Reset mid-run: load 9, 3 enabled edges (count=6), then reset=0 for one edge → count=0, state IDLE, busy=0, no underflow.
- Every scenario uses a reference model compared at negedge clk; any mismatch sets the error flag and fails the run.
